// File: rtl/receiving.sv
`timescale 1ns / 1ps
// receiving: serial receiver for 1-start / DATA_BITS-data / 1-stop character
// frames on a clock running at OVERSAMPLE x the bit rate. The line is
// synchronized, the start bit is re-checked at mid-bit, and each bit is taken
// at its centre. Completed characters are presented on data_out with a
// full / read_ack handshake and a sticky overrun flag.
//
// Optional feature macro: RX_FRAME_CHECK_EN
//   defined   - a stop sample of 0 pulses frame_err instead of completing the
//               character, then the receiver holds off until the line is high.
//   undefined - the stop sample is ignored and frame_err is tied low.
module receiving #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r_enable,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 charReceived,
    output logic                 rx_full,
    output logic                 overrun,
    output logic                 frame_err,
    input  logic                 read_ack
);

    localparam int                SCNT_W    = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        BCNT_LAST = 4'(DATA_BITS - 1);

    // BREAK_WAIT is only entered when stop-bit checking is built in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t                state;
    state_t                state_d;
    logic                  sync_meta;
    logic                  sync_in;
    logic [SCNT_W-1:0]     scnt;
    logic [SCNT_W-1:0]     scnt_d;
    logic [3:0]            bcnt;
    logic [3:0]            bcnt_d;
    logic [DATA_BITS-1:0]  sr;
    logic                  shift_en;
    logic                  stop_en;
    logic                  done_pend;
    logic                  char_ok;

    // Two-flop synchronizer; both flops idle high like the line itself.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours (sync_in sees the old
        // sync_meta, giving two full stages).
        if (reset) begin
            sync_meta <= 1'b1;
            sync_in   <= 1'b1;
        end else begin
            sync_meta <= data_in;
            sync_in   <= sync_meta;
        end
    end

    // FSM state register together with the sample and bit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_d;
            scnt  <= scnt_d;
            bcnt  <= bcnt_d;
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d  = state;
        scnt_d   = scnt;
        bcnt_d   = bcnt;
        shift_en = 1'b0;
        stop_en  = 1'b0;

        if (!r_enable) begin
            // Disabling the receiver drops any partial frame.
            state_d = IDLE;
            scnt_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state)
                IDLE: begin
                    scnt_d = '0;
                    bcnt_d = '0;
                    if (!sync_in) begin
                        state_d = START;
                    end
                end

                START: begin
                    if (scnt == SCNT_HALF) begin
                        // Mid-start-bit: still low means a real start,
                        // high means a glitch and we quietly give up.
                        scnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = sync_in ? IDLE : DATA;
                    end else begin
                        scnt_d = scnt + 1'b1;
                    end
                end

                DATA: begin
                    // Power-of-two OVERSAMPLE lets the counter wrap on its own,
                    // so it is already 0 when STOP is entered.
                    scnt_d = scnt + 1'b1;
                    if (scnt == SCNT_LAST) begin
                        shift_en = 1'b1;
                        bcnt_d   = bcnt + 1'b1;
                        if (bcnt == BCNT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end

                STOP: begin
                    scnt_d = scnt + 1'b1;
                    if (scnt == SCNT_LAST) begin
                        stop_en = 1'b1;
                        scnt_d  = '0;
`ifdef RX_FRAME_CHECK_EN
                        // A low stop sample may be the start of a break; wait
                        // for the line to return high before looking again.
                        state_d = sync_in ? IDLE : BREAK_WAIT;
`else
                        state_d = IDLE;
`endif
                    end
                end

                BREAK_WAIT: begin
                    scnt_d = '0;
                    bcnt_d = '0;
                    if (sync_in) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    scnt_d  = '0;
                    bcnt_d  = '0;
                end
            endcase
        end
    end

    // Shift register: data arrives LSB first, so each bit enters at the MSB.
    always_ff @(posedge clk) begin
        // NOTE: sr is reset even though it is pure data, so the first
        // character load can never expose an unknown value.
        if (reset) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sync_in, sr[DATA_BITS-1:1]};
        end
    end

    // Completion is registered one edge after the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_pend <= 1'b0;
        end else begin
            done_pend <= stop_en;
        end
    end

`ifdef RX_FRAME_CHECK_EN
    logic stop_bit;

    // Captured stop-bit value, consumed on the completion edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stop_bit <= 1'b1;
        end else if (stop_en) begin
            stop_bit <= sync_in;
        end
    end

    assign char_ok = stop_bit;

    // One-cycle framing-error pulse on a low stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= done_pend && !stop_bit;
        end
    end
`else
    assign char_ok   = 1'b1;
    assign frame_err = 1'b0;
`endif

    // Processor-side holding register, handshake and overrun tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out     <= '0;
            charReceived <= 1'b0;
            rx_full      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            charReceived <= 1'b0;
            if (read_ack) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end
            // Placed after the acknowledge so a coinciding completion wins.
            if (done_pend && char_ok) begin
                data_out     <= sr;
                charReceived <= 1'b1;
                rx_full      <= 1'b1;
                if (rx_full && !read_ack) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_receiving.sv
`timescale 1ns / 1ps
// tb_receiving: drives whole serial frames (including rate-skewed ones) into
// the receiver and compares the processor-side outputs against a frame-level
// model of characters received, full/overrun flags and pulse counts.
module tb_receiving;

    localparam real CLK_NS = 10.0;

    logic       clk;
    logic       reset;
    logic       r_enable;
    logic       data_in;
    logic [7:0] data_out;
    logic       charReceived;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;
    logic       read_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed pulse activity.
    int      n_pulses = 0;
    int      n_ferr   = 0;
    realtime last_pulse_t = 0.0;
    realtime last_fall    = 0.0;

    // Frame-level reference model.
    logic [7:0] m_data   = 8'h00;
    logic       m_full   = 1'b0;
    logic       m_ovr    = 1'b0;
    int         m_pulses = 0;
    int         m_ferr   = 0;

    receiving #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .r_enable    (r_enable),
        .data_in     (data_in),
        .data_out    (data_out),
        .charReceived(charReceived),
        .rx_full     (rx_full),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .read_ack    (read_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (charReceived === 1'b1) begin
            n_pulses     = n_pulses + 1;
            last_pulse_t = $realtime - CLK_NS / 2.0;
        end
        if (frame_err === 1'b1) begin
            n_ferr = n_ferr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_char(input logic [7:0] b);
        m_ovr    = m_ovr | m_full;
        m_full   = 1'b1;
        m_data   = b;
        m_pulses = m_pulses + 1;
    endtask

    task automatic model_clear();
        m_full = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s.data_out", tag), 32'(data_out), 32'(m_data));
        check($sformatf("%s.rx_full", tag),  32'(rx_full),  32'(m_full));
        check($sformatf("%s.overrun", tag),  32'(overrun),  32'(m_ovr));
        check($sformatf("%s.chars", tag),    32'(n_pulses), 32'(m_pulses));
        check($sformatf("%s.frame_errs", tag), 32'(n_ferr), 32'(m_ferr));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Send one frame with a bit period of period_clk clocks. The line is
    // optionally held low for extra_low clocks after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input real period_clk,
                              input int extra_low, input bit align);
        realtime bit_ns;
        bit_ns = period_clk * CLK_NS;
        if (align) begin
            @(posedge clk);
            #3;
        end
        data_in   = 1'b0;
        last_fall = $realtime;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
            #(bit_ns);
        end
        data_in = stop;
        #(bit_ns);
        if (extra_low > 0) begin
            data_in = 1'b0;
            #(extra_low * 10);
        end
        data_in = 1'b1;
    endtask

    task automatic do_ack();
        @(posedge clk);
        #3;
        read_ack = 1'b1;
        @(posedge clk);
        #3;
        read_ack = 1'b0;
        model_clear();
    endtask

    initial begin
        real        lat;
        logic [7:0] rb;
        real        per;

        data_in  = 1'b1;
        reset    = 1'b1;
        r_enable = 1'b1;
        read_ack = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;

        // Reset state.
        check("reset.charReceived", 32'(charReceived), 32'd0);
        check_outputs("reset");
        wait_cycles(20);

        // Single frame at exact rate, with latency from the line's falling edge.
        send_frame(8'h5A, 1'b1, 16.0, 0, 1'b1);
        wait_cycles(4);
        model_char(8'h5A);
        check_outputs("frame_5a");
        lat = (last_pulse_t - last_fall) / CLK_NS;
        check("frame_5a.latency_in_155pm1", 32'(lat >= 154.0 && lat <= 156.0), 32'd1);

        // Back-to-back frames with a zero stop-to-start gap: overrun.
        do_ack();
        check_outputs("ack1");
        send_frame(8'h01, 1'b1, 16.0, 0, 1'b1);
        send_frame(8'hFF, 1'b1, 16.0, 0, 1'b0);
        wait_cycles(4);
        model_char(8'h01);
        model_char(8'hFF);
        check_outputs("b2b");
        do_ack();
        check_outputs("b2b_ack");
        do_ack();
        check_outputs("ack_when_empty");

        // Start glitch of 5 clocks: nothing happens.
        model_char(8'h00);
        m_pulses = m_pulses - 1;
        send_frame(8'h00, 1'b1, 16.0, 0, 1'b1);
        wait_cycles(4);
        m_pulses = m_pulses + 1;
        check_outputs("zero_frame");
        @(posedge clk);
        #3;
        data_in = 1'b0;
        #50;
        data_in = 1'b1;
        wait_cycles(200);
        check_outputs("glitch");

        // Frame with a low stop bit.
        do_ack();
`ifdef RX_FRAME_CHECK_EN
        send_frame(8'hA5, 1'b0, 16.0, 48, 1'b1);
        wait_cycles(4);
        m_ferr = m_ferr + 1;
        check_outputs("bad_stop");
        wait_cycles(30);
        send_frame(8'h3E, 1'b1, 16.0, 0, 1'b1);
        wait_cycles(4);
        model_char(8'h3E);
        check_outputs("after_break");
`else
        send_frame(8'hA5, 1'b0, 16.0, 0, 1'b1);
        wait_cycles(30);
        model_char(8'hA5);
        check_outputs("bad_stop_ignored");
`endif

        // r_enable dropped in bit 4 of 0x3C, then a clean 0xC3.
        do_ack();
        wait_cycles(10);
        fork
            send_frame(8'h3C, 1'b1, 16.0, 0, 1'b1);
            begin
                @(posedge clk);
                #3;
                #850;
                r_enable = 1'b0;
            end
        join
        wait_cycles(2);
        r_enable = 1'b1;
        wait_cycles(20);
        check_outputs("disable_abort");
        send_frame(8'hC3, 1'b1, 16.0, 0, 1'b1);
        wait_cycles(4);
        model_char(8'hC3);
        check_outputs("frame_c3");

        // Reset in bit 4 of 0x3C clears everything.
        fork
            send_frame(8'h3C, 1'b1, 16.0, 0, 1'b1);
            begin
                @(posedge clk);
                #3;
                #850;
                reset = 1'b1;
            end
        join
        wait_cycles(2);
        reset = 1'b0;
        m_data = 8'h00;
        model_clear();
        check("reset_abort.charReceived", 32'(charReceived), 32'd0);
        check_outputs("reset_abort");
        wait_cycles(20);

        // Bit-rate tolerance: +3% and -3%.
        send_frame(8'h96, 1'b1, 16.0 * 1.03, 0, 1'b1);
        wait_cycles(4);
        model_char(8'h96);
        check_outputs("rate_plus3");
        do_ack();
        send_frame(8'h96, 1'b1, 16.0 * 0.97, 0, 1'b1);
        wait_cycles(4);
        model_char(8'h96);
        check_outputs("rate_minus3");

        // Random characters, rates within +-2%, random acknowledges and gaps.
        for (int k = 0; k < 10; k++) begin
            rb  = 8'($urandom_range(0, 255));
            per = 16.0 * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
            end
            wait_cycles($urandom_range(0, 10));
            send_frame(rb, 1'b1, per, 0, 1'b1);
            wait_cycles(4);
            model_char(rb);
            check_outputs($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
